// File: rtl/mul_share_pkg.sv
// Shared types and defaults for the multiplier-sharing sequencer.
package mul_share_pkg;

  localparam int DEF_NREQ     = 4;
  localparam int DEF_MAX_ITER = 255;

  localparam logic OP_A = 1'b0;
  localparam logic OP_B = 1'b1;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LDA  = 3'd1,
    LDB  = 3'd2,
    MUL  = 3'd3,
    DONE = 3'd4
  } state_t;

endpackage

// File: rtl/mul_share_ctrl_if.sv
// Requester handshake, operand-bus steering and datapath strobes of the shared multiplier.
interface mul_share_ctrl_if #(
  parameter int NREQ  = mul_share_pkg::DEF_NREQ,
  parameter int IDX_W = $clog2(NREQ)
);
  import mul_share_pkg::*;

  // Handshake: a requester raises req (level) and holds operands while its gnt
  // bit is high; ack pulses for one cycle when P holds the product, err pulses
  // with ack on a watchdog abort, and the requester drops req the next cycle.
  logic [NREQ-1:0]  req;
  logic [NREQ-1:0]  gnt;
  logic [NREQ-1:0]  ack;
  logic             err;
  logic             busy;
  logic [IDX_W-1:0] bus_sel;
  logic             bus_op;
  logic             eqz;
  logic             ldA;
  logic             ldB;
  logic             ldP;
  logic             clrP;
  logic             decQ;
  state_t           dbg_state;

  modport master (
    input  req, eqz,
    output gnt, ack, err, busy, bus_sel, bus_op,
    output ldA, ldB, ldP, clrP, decQ, dbg_state
  );

  modport slave (
    output req, eqz,
    input  gnt, ack, err, busy, bus_sel, bus_op,
    input  ldA, ldB, ldP, clrP, decQ, dbg_state
  );

endinterface

// File: rtl/mul_share_ctrl_rr_arbiter.sv
// Combinational round-robin pick: first asserted request scanning upward from ptr+1 with wrap.
module rr_arbiter #(
  parameter int NREQ  = 4,
  parameter int IDX_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic [NREQ-1:0]  win_oh,
  output logic [IDX_W-1:0] win_idx,
  output logic             win_vld
);

  logic [IDX_W-1:0] cand;

  always_comb begin
    win_oh  = '0;
    win_idx = '0;
    win_vld = 1'b0;
    cand    = '0;
    // The last candidate is ptr itself, so the previous winner ranks lowest.
    for (int i = 1; i <= NREQ; i++) begin
      cand = IDX_W'((int'(ptr) + i) % NREQ);
      if (!win_vld && req[cand]) begin
        win_vld = 1'b1;
        win_idx = cand;
      end
    end
    if (win_vld) win_oh[win_idx] = 1'b1;
  end

endmodule

// File: rtl/mul_share_ctrl.sv
// Sequencer that time-shares one repeated-addition multiplier among NREQ requesters,
// with round-robin arbitration and an iteration watchdog.
module mul_share_ctrl
  import mul_share_pkg::*;
#(
  parameter int NREQ     = DEF_NREQ,
  parameter int MAX_ITER = DEF_MAX_ITER,
  parameter int IDX_W    = $clog2(NREQ),
  parameter int IT_W     = $clog2(MAX_ITER + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  mul_share_ctrl_if.master  bus
);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] ptr_q;
  logic [IDX_W-1:0] gidx_q;
  logic [NREQ-1:0]  gnt_q;
  logic [IT_W-1:0]  iter_q;
  logic             err_q;

  logic [NREQ-1:0]  win_oh;
  logic [IDX_W-1:0] win_idx;
  logic             win_vld;
  logic             iter_left;

  rr_arbiter #(.NREQ(NREQ), .IDX_W(IDX_W)) u_arb (
    .req     (bus.req),
    .ptr     (ptr_q),
    .win_oh  (win_oh),
    .win_idx (win_idx),
    .win_vld (win_vld)
  );

  assign iter_left     = (iter_q < IT_W'(MAX_ITER));
  assign bus.dbg_state = state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= IDX_W'(NREQ - 1);
      gidx_q  <= '0;
      gnt_q   <= '0;
      iter_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (win_vld) begin
            gidx_q <= win_idx;
            gnt_q  <= win_oh;
            ptr_q  <= win_idx;
          end
        end
        LDB:  iter_q <= '0;
        MUL: begin
          // eqz wins over the watchdog when both land in the same cycle.
          if (!bus.eqz) begin
            if (iter_left) iter_q <= iter_q + IT_W'(1);
            else           err_q  <= 1'b1;
          end
        end
        DONE:    err_q <= 1'b0;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d     = state_q;
    bus.gnt     = '0;
    bus.ack     = '0;
    bus.err     = 1'b0;
    bus.busy    = (state_q != IDLE);
    bus.bus_sel = '0;
    bus.bus_op  = OP_A;
    bus.ldA     = 1'b0;
    bus.ldB     = 1'b0;
    bus.ldP     = 1'b0;
    bus.clrP    = 1'b0;
    bus.decQ    = 1'b0;
    case (state_q)
      IDLE: begin
        if (win_vld) state_d = LDA;
      end
      LDA: begin
        bus.gnt     = gnt_q;
        bus.bus_sel = gidx_q;
        bus.bus_op  = OP_A;
        bus.ldA     = 1'b1;
        state_d     = LDB;
      end
      LDB: begin
        bus.gnt     = gnt_q;
        bus.bus_sel = gidx_q;
        bus.bus_op  = OP_B;
        bus.ldB     = 1'b1;
        bus.clrP    = 1'b1;
        state_d     = MUL;
      end
      MUL: begin
        bus.gnt     = gnt_q;
        bus.bus_sel = gidx_q;
        bus.bus_op  = OP_B;
        if (bus.eqz) begin
          state_d = DONE;
        end else if (iter_left) begin
          bus.ldP  = 1'b1;
          bus.decQ = 1'b1;
        end else begin
          state_d = DONE;
        end
      end
      DONE: begin
        bus.gnt     = gnt_q;
        bus.bus_sel = gidx_q;
        bus.bus_op  = OP_B;
        bus.ack     = gnt_q;
        bus.err     = err_q;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mul_share_ctrl.sv
// Bench for mul_share_ctrl: a behavioural A/B/P/Q datapath driven by the DUT strobes,
// plus an arithmetic reference (product, latency, pulse count, rr order) per transaction.
module tb_mul_share_ctrl;
  import mul_share_pkg::*;

  localparam int NREQ     = 4;
  localparam int MAX_ITER = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  mul_share_ctrl_if #(.NREQ(NREQ)) bus_if ();

  mul_share_ctrl #(.NREQ(NREQ), .MAX_ITER(MAX_ITER)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  logic [7:0]  opa [NREQ];
  logic [7:0]  opb [NREQ];
  logic [7:0]  bus_val, dp_a, dp_q;
  logic [15:0] dp_p;
  bit          force_eqz0;

  assign bus_val   = bus_if.bus_op ? opb[bus_if.bus_sel] : opa[bus_if.bus_sel];
  assign bus_if.eqz = force_eqz0 ? 1'b0 : (dp_q == 8'd0);

  always @(posedge clk) begin
    if (bus_if.ldA)  dp_a <= bus_val;
    if (bus_if.ldB)  dp_q <= bus_val;
    if (bus_if.decQ) dp_q <= dp_q - 8'd1;
    if (bus_if.clrP)     dp_p <= 16'd0;
    else if (bus_if.ldP) dp_p <= dp_p + {8'd0, dp_a};
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;
  int model_ptr = NREQ - 1;
  int lda_cyc = 0;
  int ldp_cnt = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (bus_if.ldA) begin
      lda_cyc = cyc;
      ldp_cnt = 0;
    end
    if (bus_if.ldP) ldp_cnt++;
    check("ack_onehot", ($countones(bus_if.ack) <= 1), 1);
    check("err_without_ack", (bus_if.err && bus_if.ack == '0), 0);
  end

  function automatic int rr_pick(input logic [NREQ-1:0] pend, input int ptr);
    for (int k = 1; k <= NREQ; k++)
      if (pend[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
    return 0;
  endfunction

  // Waits for one ack and checks it against the reference for requester idx,
  // whose request was sampled in IDLE cycle t0.
  task automatic expect_txn(input int idx, input int t0, input bit keep);
    int a, b, n, k;
    bit e;
    a = opa[idx];
    b = opb[idx];
    e = force_eqz0 || (b > MAX_ITER);
    n = e ? MAX_ITER : b;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (bus_if.ack == '0 && k < 100);
    if (bus_if.ack == '0) begin
      checks++;
      errors++;
      $error("FAIL ack_timeout: observed=none expected=ack[%0d]", idx);
    end else begin
      check("lda_cycle", lda_cyc, t0 + 1);
      check("ack", bus_if.ack, 32'(1) << idx);
      check("gnt_at_ack", bus_if.gnt, 32'(1) << idx);
      check("bus_sel", bus_if.bus_sel, idx);
      check("err", bus_if.err, e);
      check("product", dp_p, (a * n) & 16'hFFFF);
      check("ldp_pulses", ldp_cnt, n);
      check("latency", cyc - t0, n + 4);
    end
    model_ptr = idx;
    if (keep) begin
      opa[idx] = 8'($urandom_range(0, 255));
      opb[idx] = 8'($urandom_range(0, 12));
    end else begin
      bus_if.req[idx] = 1'b0;
    end
  endtask

  int rr_order [5] = '{0, 1, 2, 3, 0};
  logic [NREQ-1:0] pend;
  int t0, w;

  initial begin
    bus_if.req = '0;
    force_eqz0 = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      opa[i] = 8'($urandom_range(0, 255));
      opb[i] = 8'($urandom_range(0, 12));
    end

    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_gnt", bus_if.gnt, 0);
    check("rst_ack", bus_if.ack, 0);
    check("rst_err", bus_if.err, 0);
    check("rst_busy", bus_if.busy, 0);
    check("rst_strobes", {bus_if.ldA, bus_if.ldB, bus_if.ldP, bus_if.clrP, bus_if.decQ}, 0);
    check("rst_bus", {bus_if.bus_sel, bus_if.bus_op}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // req0 alone, A=5 B=3: product 15 at ack 7 cycles after sample.
    opa[0] = 8'd5; opb[0] = 8'd3;
    bus_if.req = 4'b0001;
    expect_txn(0, cyc, 1'b0);

    // B=0: one MUL cycle, no ldP, P stays 0.
    opa[2] = 8'd9; opb[2] = 8'd0;
    bus_if.req = 4'b0100;
    expect_txn(2, cyc + 1, 1'b0);

    // B equal to MAX_ITER completes normally; also leaves the pointer on 3.
    opa[3] = 8'($urandom_range(1, 255)); opb[3] = 8'(MAX_ITER);
    bus_if.req = 4'b1000;
    expect_txn(3, cyc + 1, 1'b0);

    // All four held and re-asserted after each ack.
    bus_if.req = 4'b1111;
    for (int k = 0; k < 5; k++) expect_txn(rr_order[k], cyc + 1, 1'b1);
    bus_if.req = '0;

    // Last grant 2, then 1 and 3 together: 3 first, then 1.
    bus_if.req = 4'b0100;
    expect_txn(2, cyc + 1, 1'b0);
    bus_if.req = 4'b1010;
    expect_txn(3, cyc + 1, 1'b0);
    expect_txn(1, cyc + 1, 1'b0);

    // Watchdog: eqz held low forces MAX_ITER pulses and err with ack.
    force_eqz0 = 1'b1;
    opa[0] = 8'($urandom_range(1, 255)); opb[0] = 8'($urandom_range(0, 3));
    bus_if.req = 4'b0001;
    expect_txn(0, cyc + 1, 1'b0);
    force_eqz0 = 1'b0;
    opb[1] = 8'd3;
    bus_if.req = 4'b0010;
    expect_txn(1, cyc + 1, 1'b0);

    // Random request patterns served in round-robin order.
    for (int r = 0; r < 8; r++) begin
      pend = 4'($urandom_range(1, 15));
      for (int i = 0; i < NREQ; i++) begin
        if (pend[i]) begin
          opa[i] = 8'($urandom_range(0, 255));
          opb[i] = 8'($urandom_range(0, 12));
        end
      end
      bus_if.req = pend;
      while (pend != '0) begin
        w = rr_pick(pend, model_ptr);
        expect_txn(w, cyc + 1, 1'b0);
        pend[w] = 1'b0;
      end
    end

    // Async reset in the second MUL cycle, then restart with the pointer reset.
    opa[0] = 8'($urandom_range(1, 255)); opb[0] = 8'd5;
    opa[1] = 8'($urandom_range(1, 255)); opb[1] = 8'($urandom_range(0, 12));
    bus_if.req = 4'b0001;
    t0 = cyc + 1;
    for (int k = 0; k < 20 && cyc < t0 + 4; k++) @(negedge clk);
    check("mid_mul_ldP", bus_if.ldP, 1);
    rst_n = 1'b0;
    #1;
    check("async_busy", bus_if.busy, 0);
    check("async_gnt", bus_if.gnt, 0);
    check("async_strobes", {bus_if.ldA, bus_if.ldB, bus_if.ldP, bus_if.clrP, bus_if.decQ}, 0);
    bus_if.req = 4'b0011;
    @(negedge clk);
    rst_n = 1'b1;
    model_ptr = NREQ - 1;
    expect_txn(0, cyc, 1'b0);
    expect_txn(1, cyc + 1, 1'b0);

    repeat (2) @(negedge clk);
    check("idle_gnt", bus_if.gnt, 0);
    check("idle_ack", bus_if.ack, 0);
    check("idle_busy", bus_if.busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
